// File: rtl/riscv_clint_presc_if.sv
// AXI4 single-beat bus bundle between the tile IO crossbar and the CLINT.
// Only the fields the CLINT looks at are carried; the remaining AXI fields are
// ignored by the slave and so are left out of the bundle.
interface riscv_clint_presc_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned ID_W   = 10,
    parameter int unsigned USER_W = 1
);
    logic [ID_W-1:0]     aw_id;
    logic [ADDR_W-1:0]   aw_addr;
    logic [7:0]          aw_len;
    logic [2:0]          aw_size;
    logic                aw_valid;
    logic                aw_ready;

    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;
    logic                w_valid;
    logic                w_ready;

    logic [ID_W-1:0]     b_id;
    logic [1:0]          b_resp;
    logic [USER_W-1:0]   b_user;
    logic                b_valid;
    logic                b_ready;

    logic [ID_W-1:0]     ar_id;
    logic [ADDR_W-1:0]   ar_addr;
    logic [7:0]          ar_len;
    logic [2:0]          ar_size;
    logic                ar_valid;
    logic                ar_ready;

    logic [ID_W-1:0]     r_id;
    logic [DATA_W-1:0]   r_data;
    logic [1:0]          r_resp;
    logic                r_last;
    logic [USER_W-1:0]   r_user;
    logic                r_valid;
    logic                r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/riscv_clint_presc.sv
// CLINT with per-hart msip/mtimecmp, shared 64-bit mtime driven by a
// programmable prescaler, and a single-beat AXI4 slave front end.
module riscv_clint_presc #(
    parameter int unsigned AXI_ADDR_WIDTH   = 64,
    parameter int unsigned AXI_DATA_WIDTH   = 64,
    parameter int unsigned AXI_ID_WIDTH_SLV = 10,
    parameter int unsigned AXI_USER_WIDTH   = 1,
    parameter int unsigned NR_CORES         = 1,
    parameter int unsigned PRESC_RST        = 1
) (
    input  logic                clk,
    input  logic                rstn,
    riscv_clint_presc_if.slave  axi,
    output logic [NR_CORES-1:0] timer_irq,
    output logic [NR_CORES-1:0] ipi
);
    typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
    typedef enum logic [0:0] {RIdle, RResp} r_state_e;
    typedef enum logic [2:0] {TgtNone, TgtMsip, TgtCmp, TgtCtrl, TgtTime} tgt_e;

    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlvErr = 2'b10;

    w_state_e w_state_q, w_state_d;
    r_state_e r_state_q, r_state_d;
    logic     active_q;

    logic [AXI_ID_WIDTH_SLV-1:0] aw_id_q, r_id_q;
    logic [15:0]                 aw_addr_q;
    logic                        aw_err_q;
    logic [1:0]                  b_resp_q, r_resp_q;
    logic [AXI_DATA_WIDTH-1:0]   r_data_q;

    logic [63:0]         mtime_q, mtime_d;
    logic [15:0]         cnt_q, cnt_d, presc_q, presc_d;
    logic                en_q, en_d;
    logic [63:0]         mtimecmp_q [NR_CORES];
    logic [NR_CORES-1:0] msip_q, timer_irq_q, ipi_q;

    tgt_e        wr_tgt, rd_tgt;
    logic        wr_hs, wr_ok, rd_err;
    logic [31:0] wr_msip_idx, wr_cmp_idx, rd_msip_idx, rd_cmp_idx;
    logic [63:0] rd_data;

    function automatic tgt_e decode(input logic [15:0] a);
        tgt_e t;
        t = TgtNone;
        if (a[15:14] == 2'b00) begin
            if (32'(a[13:2]) < NR_CORES) t = TgtMsip;
        end else if (a[15:14] == 2'b01) begin
            if (32'(a[13:3]) < NR_CORES) t = TgtCmp;
        end else if (a[15:3] == 13'h17FE) begin
            t = TgtCtrl;
        end else if (a[15:3] == 13'h17FF) begin
            t = TgtTime;
        end
        return t;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                          input logic [7:0] strb);
        logic [63:0] r;
        for (int b = 0; b < 8; b++) r[b*8 +: 8] = strb[b] ? wd[b*8 +: 8] : old[b*8 +: 8];
        return r;
    endfunction

    assign wr_tgt      = decode(aw_addr_q);
    assign rd_tgt      = decode(axi.ar_addr[15:0]);
    assign wr_msip_idx = 32'(aw_addr_q[13:2]);
    assign wr_cmp_idx  = 32'(aw_addr_q[13:3]);
    assign rd_msip_idx = 32'(axi.ar_addr[13:2]);
    assign rd_cmp_idx  = 32'(axi.ar_addr[13:3]);
    assign wr_hs       = axi.w_valid && axi.w_ready;
    assign wr_ok       = wr_hs && !aw_err_q && (wr_tgt != TgtNone);
    assign rd_err      = (rd_tgt == TgtNone) || (axi.ar_len != 8'd0);

    // Write channel FSM: AW, then one W beat, then B held until accepted.
    always_comb begin
        w_state_d    = w_state_q;
        axi.aw_ready = 1'b0;
        axi.w_ready  = 1'b0;
        axi.b_valid  = 1'b0;
        unique case (w_state_q)
            WIdle: begin
                axi.aw_ready = active_q;
                if (active_q && axi.aw_valid) w_state_d = WData;
            end
            WData: begin
                axi.w_ready = 1'b1;
                if (axi.w_valid) w_state_d = WResp;
            end
            WResp: begin
                axi.b_valid = 1'b1;
                if (axi.b_ready) w_state_d = WIdle;
            end
            default: w_state_d = WIdle;
        endcase
    end

    // Read channel FSM: data is snapshotted at AR, so R stays stable under backpressure.
    always_comb begin
        r_state_d    = r_state_q;
        axi.ar_ready = 1'b0;
        axi.r_valid  = 1'b0;
        axi.r_last   = 1'b0;
        unique case (r_state_q)
            RIdle: begin
                axi.ar_ready = active_q;
                if (active_q && axi.ar_valid) r_state_d = RResp;
            end
            RResp: begin
                axi.r_valid = 1'b1;
                axi.r_last  = 1'b1;
                if (axi.r_ready) r_state_d = RIdle;
            end
            default: r_state_d = RIdle;
        endcase
    end

    // FSM state and the ready-enable that keeps the slave quiet while in reset.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state_q <= WIdle;
            r_state_q <= RIdle;
            active_q  <= 1'b0;
        end else begin
            w_state_q <= w_state_d;
            r_state_q <= r_state_d;
            active_q  <= 1'b1;
        end
    end

    // Read data mux over the current register contents.
    always_comb begin
        rd_data = '0;
        unique case (rd_tgt)
            TgtMsip: begin
                for (int i = 0; i < NR_CORES; i++) begin
                    if (rd_msip_idx == 32'(i)) begin
                        rd_data = axi.ar_addr[2] ? {31'b0, msip_q[i], 32'b0} : {63'b0, msip_q[i]};
                    end
                end
            end
            TgtCmp: begin
                for (int i = 0; i < NR_CORES; i++) begin
                    if (rd_cmp_idx == 32'(i)) rd_data = mtimecmp_q[i];
                end
            end
            TgtCtrl: rd_data = {32'b0, en_q, 15'b0, presc_q};
            TgtTime: rd_data = mtime_q;
            default: rd_data = '0;
        endcase
        if (rd_err) rd_data = '0;
    end

    // Transaction bookkeeping: AW latch, B response and R snapshot.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_id_q   <= '0;
            aw_addr_q <= '0;
            aw_err_q  <= 1'b0;
            b_resp_q  <= RespOkay;
            r_id_q    <= '0;
            r_data_q  <= '0;
            r_resp_q  <= RespOkay;
        end else begin
            if (axi.aw_valid && axi.aw_ready) begin
                aw_id_q   <= axi.aw_id;
                aw_addr_q <= axi.aw_addr[15:0];
                aw_err_q  <= (axi.aw_len != 8'd0);
            end
            if (wr_hs) b_resp_q <= wr_ok ? RespOkay : RespSlvErr;
            if (axi.ar_valid && axi.ar_ready) begin
                r_id_q   <= axi.ar_id;
                r_data_q <= rd_data;
                r_resp_q <= rd_err ? RespSlvErr : RespOkay;
            end
        end
    end

    // Timebase next state; a bus write to mtime overrides that cycle's increment.
    always_comb begin
        cnt_d   = cnt_q;
        mtime_d = mtime_q;
        presc_d = presc_q;
        en_d    = en_q;
        if (en_q) begin
            if (cnt_q == presc_q) begin
                cnt_d   = '0;
                mtime_d = mtime_q + 64'd1;
            end else begin
                cnt_d = cnt_q + 16'd1;
            end
        end
        if (wr_ok && wr_tgt == TgtCtrl) begin
            cnt_d = '0;
            if (axi.w_strb[0]) presc_d[7:0]  = axi.w_data[7:0];
            if (axi.w_strb[1]) presc_d[15:8] = axi.w_data[15:8];
            if (axi.w_strb[3]) en_d          = axi.w_data[31];
        end
        if (wr_ok && wr_tgt == TgtTime) mtime_d = merge(mtime_q, axi.w_data, axi.w_strb);
    end

    // Timebase registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q   <= '0;
            mtime_q <= '0;
            presc_q <= 16'(PRESC_RST);
            en_q    <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            mtime_q <= mtime_d;
            presc_q <= presc_d;
            en_q    <= en_d;
        end
    end

    // Per-hart msip/mtimecmp storage and registered interrupt outputs.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            msip_q      <= '0;
            timer_irq_q <= '0;
            ipi_q       <= '0;
            for (int i = 0; i < NR_CORES; i++) mtimecmp_q[i] <= '1;
        end else begin
            for (int i = 0; i < NR_CORES; i++) begin
                if (wr_ok && wr_tgt == TgtMsip && wr_msip_idx == 32'(i) &&
                    (aw_addr_q[2] ? axi.w_strb[4] : axi.w_strb[0])) begin
                    msip_q[i] <= aw_addr_q[2] ? axi.w_data[32] : axi.w_data[0];
                end
                if (wr_ok && wr_tgt == TgtCmp && wr_cmp_idx == 32'(i)) begin
                    mtimecmp_q[i] <= merge(mtimecmp_q[i], axi.w_data, axi.w_strb);
                end
                timer_irq_q[i] <= (mtime_q >= mtimecmp_q[i]);
            end
            ipi_q <= msip_q;
        end
    end

    assign axi.b_id   = aw_id_q;
    assign axi.b_resp = b_resp_q;
    assign axi.b_user = {AXI_USER_WIDTH{1'b0}};
    assign axi.r_id   = r_id_q;
    assign axi.r_data = r_data_q;
    assign axi.r_resp = r_resp_q;
    assign axi.r_user = {AXI_USER_WIDTH{1'b0}};
    assign timer_irq  = timer_irq_q;
    assign ipi        = ipi_q;

    logic unused_bits;
    assign unused_bits = ^{axi.aw_addr[AXI_ADDR_WIDTH-1:16], axi.ar_addr[AXI_ADDR_WIDTH-1:16],
                           axi.ar_addr[1:0], aw_addr_q[1:0], axi.aw_size, axi.ar_size,
                           axi.w_last};
endmodule

// File: tb/tb_riscv_clint_presc.sv
// Directed bench for riscv_clint_presc: expected B/R responses are queued when
// a transaction is issued and popped when the DUT answers.
`timescale 1ns/1ps
module tb_riscv_clint_presc;
    logic       clk = 1'b0;
    logic       rstn;
    logic [0:0] timer_irq, ipi;
    int         n_cmp = 0;
    int         n_fail = 0;
    int         cyc = 0;

    typedef struct packed {logic [1:0] resp; logic [9:0] id;} bexp_t;
    typedef struct packed {logic [63:0] data; logic [1:0] resp; logic [9:0] id;} rexp_t;
    bexp_t      bq[$];
    rexp_t      rq[$];
    logic [9:0] next_id = 10'h005;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    riscv_clint_presc_if #(.ADDR_W(64), .DATA_W(64), .ID_W(10), .USER_W(1)) axi ();

    riscv_clint_presc #(
        .AXI_ADDR_WIDTH(64), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH_SLV(10),
        .AXI_USER_WIDTH(1), .NR_CORES(1), .PRESC_RST(1)
    ) dut (
        .clk(clk), .rstn(rstn), .axi(axi), .timer_irq(timer_irq), .ipi(ipi)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called and returns at a falling edge.
    task automatic do_write(input string tag, input logic [15:0] addr, input logic [63:0] data,
                            input logic [7:0] strb, input logic [7:0] len,
                            input logic [1:0] eresp, input int stall, output int wc);
        bexp_t e;
        int n;
        e.resp = eresp;
        e.id = next_id;
        next_id = next_id + 10'd3;
        bq.push_back(e);
        axi.aw_id = e.id; axi.aw_addr = {48'h0, addr}; axi.aw_len = len;
        axi.aw_size = 3'd3; axi.aw_valid = 1'b1;
        n = 0;
        while (axi.aw_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check({tag, "_aw_wait"}, 64'(n < 20), 64'd1);
        @(negedge clk);
        axi.aw_valid = 1'b0;
        axi.w_data = data; axi.w_strb = strb; axi.w_last = (len == 8'd0); axi.w_valid = 1'b1;
        n = 0;
        while (axi.w_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check({tag, "_w_wait"}, 64'(n < 20), 64'd1);
        @(negedge clk);
        wc = cyc;
        axi.w_valid = 1'b0;
        n = 0;
        while (axi.b_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check({tag, "_b_wait"}, 64'(n < 20), 64'd1);
        for (int i = 0; i < stall; i++) begin
            check({tag, "_bhold_valid"}, 64'(axi.b_valid), 64'd1);
            check({tag, "_bhold_resp"}, 64'(axi.b_resp), 64'(bq[0].resp));
            check({tag, "_bhold_id"}, 64'(axi.b_id), 64'(bq[0].id));
            @(negedge clk);
        end
        e = bq.pop_front();
        check({tag, "_bresp"}, 64'(axi.b_resp), 64'(e.resp));
        check({tag, "_bid"}, 64'(axi.b_id), 64'(e.id));
        axi.b_ready = 1'b1;
        @(negedge clk);
        axi.b_ready = 1'b0;
        check({tag, "_b_done"}, 64'(axi.b_valid), 64'd0);
    endtask

    // Called and returns at a falling edge; data compared only when chk is set.
    task automatic do_read(input string tag, input logic [15:0] addr, input logic [7:0] len,
                           input logic chk, input logic [63:0] edata, input logic [1:0] eresp,
                           input int stall, output logic [63:0] rdata);
        rexp_t e;
        int n;
        e.data = edata;
        e.resp = eresp;
        e.id = next_id;
        next_id = next_id + 10'd7;
        rq.push_back(e);
        axi.ar_id = e.id; axi.ar_addr = {48'h0, addr}; axi.ar_len = len;
        axi.ar_size = 3'd3; axi.ar_valid = 1'b1;
        n = 0;
        while (axi.ar_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check({tag, "_ar_wait"}, 64'(n < 20), 64'd1);
        @(negedge clk);
        axi.ar_valid = 1'b0;
        n = 0;
        while (axi.r_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check({tag, "_r_wait"}, 64'(n < 20), 64'd1);
        for (int i = 0; i < stall; i++) begin
            check({tag, "_rhold_valid"}, 64'(axi.r_valid), 64'd1);
            check({tag, "_rhold_resp"}, 64'(axi.r_resp), 64'(rq[0].resp));
            if (chk) check({tag, "_rhold_data"}, axi.r_data, rq[0].data);
            @(negedge clk);
        end
        e = rq.pop_front();
        check({tag, "_rresp"}, 64'(axi.r_resp), 64'(e.resp));
        check({tag, "_rid"}, 64'(axi.r_id), 64'(e.id));
        check({tag, "_rlast"}, 64'(axi.r_last), 64'd1);
        if (chk) check({tag, "_rdata"}, axi.r_data, e.data);
        rdata = axi.r_data;
        axi.r_ready = 1'b1;
        @(negedge clk);
        axi.r_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int wc, n, delta;
        logic [63:0] t1, t2, t3, d;

        rstn = 1'b0;
        axi.aw_id = '0; axi.aw_addr = '0; axi.aw_len = '0; axi.aw_size = '0; axi.aw_valid = 1'b0;
        axi.w_data = '0; axi.w_strb = '0; axi.w_last = 1'b0; axi.w_valid = 1'b0;
        axi.b_ready = 1'b0;
        axi.ar_id = '0; axi.ar_addr = '0; axi.ar_len = '0; axi.ar_size = '0; axi.ar_valid = 1'b0;
        axi.r_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_aw_ready", 64'(axi.aw_ready), 64'd0);
        check("rst_ar_ready", 64'(axi.ar_ready), 64'd0);
        check("rst_b_valid", 64'(axi.b_valid), 64'd0);
        check("rst_r_valid", 64'(axi.r_valid), 64'd0);
        check("rst_timer_irq", 64'(timer_irq), 64'd0);
        check("rst_ipi", 64'(ipi), 64'd0);

        // Prescaler 1 after reset: mtime advances once every two clocks.
        rstn = 1'b1;
        repeat (10) @(negedge clk);
        do_read("mtime_rst", 16'hBFF8, 8'd0, 1'b0, 64'd0, 2'b00, 0, t1);
        check("mtime_rst_range", 64'(t1 >= 64'd4 && t1 <= 64'd6), 64'd1);
        check("idle_timer_irq", 64'(timer_irq), 64'd0);
        do_read("ctrl_rst", 16'hBFF0, 8'd0, 1'b1, 64'h8000_0001, 2'b00, 0, d);

        // Software interrupt.
        do_write("msip_set", 16'h0000, 64'd1, 8'h0F, 8'd0, 2'b00, 0, wc);
        check("ipi_set", 64'(ipi), 64'd1);
        do_read("msip_rd", 16'h0000, 8'd0, 1'b1, 64'd1, 2'b00, 0, d);
        do_read("msip_hart1", 16'h0004, 8'd0, 1'b1, 64'd0, 2'b10, 0, d);
        do_write("msip_clr", 16'h0000, 64'd0, 8'h0F, 8'd0, 2'b00, 0, wc);
        check("ipi_clr", 64'(ipi), 64'd0);

        // Timer interrupt with prescaler 0.
        do_write("ctrl_presc0", 16'hBFF0, 64'h8000_0000, 8'h0F, 8'd0, 2'b00, 0, wc);
        do_write("cmp_100", 16'h4000, 64'd100, 8'hFF, 8'd0, 2'b00, 0, wc);
        check("irq_before", 64'(timer_irq), 64'd0);
        do_write("mtime_90", 16'hBFF8, 64'd90, 8'hFF, 8'd0, 2'b00, 0, wc);
        n = 0;
        while (timer_irq[0] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        check("irq_rise_wait", 64'(n < 40), 64'd1);
        delta = cyc - wc;
        check("irq_rise_latency", 64'(delta >= 10 && delta <= 12), 64'd1);
        do_read("mtime_after_irq", 16'hBFF8, 8'd0, 1'b0, 64'd0, 2'b00, 0, t1);
        check("mtime_ge_cmp", 64'(t1 >= 64'd100), 64'd1);
        do_write("cmp_ones", 16'h4000, 64'hFFFF_FFFF_FFFF_FFFF, 8'hFF, 8'd0, 2'b00, 0, wc);
        check("irq_fall", 64'(timer_irq), 64'd0);

        // Global enable.
        do_write("ctrl_dis", 16'hBFF0, 64'h0, 8'h0F, 8'd0, 2'b00, 0, wc);
        do_read("mtime_frz1", 16'hBFF8, 8'd0, 1'b0, 64'd0, 2'b00, 0, t1);
        repeat (20) @(negedge clk);
        do_read("mtime_frz2", 16'hBFF8, 8'd0, 1'b0, 64'd0, 2'b00, 0, t2);
        check("mtime_frozen", t2, t1);
        do_write("mtime_set", 16'hBFF8, 64'h0000_0000_0000_1234, 8'hFF, 8'd0, 2'b00, 0, wc);
        do_write("mtime_byte", 16'hBFF8, 64'hFFFF_FFFF_FFFF_FFAB, 8'h01, 8'd0, 2'b00, 0, wc);
        do_read("mtime_strb", 16'hBFF8, 8'd0, 1'b1, 64'h0000_0000_0000_12AB, 2'b00, 0, d);
        do_write("ctrl_en", 16'hBFF0, 64'h8000_0000, 8'h0F, 8'd0, 2'b00, 0, wc);
        do_read("mtime_run", 16'hBFF8, 8'd0, 1'b0, 64'd0, 2'b00, 0, t3);
        check("mtime_resumed", 64'(t3 > 64'h12AB), 64'd1);

        // Partial strobe on mtimecmp.
        do_write("cmp_hi", 16'h4000, 64'h1122_3344_5566_7788, 8'hF0, 8'd0, 2'b00, 0, wc);
        do_read("cmp_hi_rd", 16'h4000, 8'd0, 1'b1, 64'h1122_3344_FFFF_FFFF, 2'b00, 0, d);

        // Error responses leave state untouched.
        do_read("ar_len3", 16'hBFF8, 8'd3, 1'b1, 64'd0, 2'b10, 0, d);
        do_read("ar_unmapped", 16'h8000, 8'd0, 1'b1, 64'd0, 2'b10, 0, d);
        do_write("aw_unmapped", 16'h8000, 64'hDEAD, 8'hFF, 8'd0, 2'b10, 0, wc);
        do_write("aw_len1", 16'h4000, 64'h5, 8'hFF, 8'd1, 2'b10, 0, wc);
        do_write("aw_hart1", 16'h4008, 64'h5, 8'hFF, 8'd0, 2'b10, 0, wc);
        do_read("cmp_unchanged", 16'h4000, 8'd0, 1'b1, 64'h1122_3344_FFFF_FFFF, 2'b00, 0, d);
        check("ipi_unchanged", 64'(ipi), 64'd0);

        // Backpressure on B and R.
        do_write("msip_stall", 16'h0000, 64'd1, 8'h0F, 8'd0, 2'b00, 5, wc);
        do_read("cmp_stall", 16'h4000, 8'd0, 1'b1, 64'h1122_3344_FFFF_FFFF, 2'b00, 5, d);
        check("ipi_pre_rst", 64'(ipi), 64'd1);

        // Reset in the middle of a write.
        axi.aw_id = 10'h3A5; axi.aw_addr = 64'h0; axi.aw_len = 8'd0; axi.aw_valid = 1'b1;
        n = 0;
        while (axi.aw_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        check("midrst_aw_wait", 64'(n < 20), 64'd1);
        @(negedge clk);
        axi.aw_valid = 1'b0;
        check("midrst_in_wdata", 64'(axi.w_ready), 64'd1);
        rstn = 1'b0;
        #1;
        check("midrst_w_ready", 64'(axi.w_ready), 64'd0);
        check("midrst_aw_ready", 64'(axi.aw_ready), 64'd0);
        check("midrst_b_valid", 64'(axi.b_valid), 64'd0);
        check("midrst_b_id", 64'(axi.b_id), 64'd0);
        check("midrst_r_valid", 64'(axi.r_valid), 64'd0);
        check("midrst_ipi", 64'(ipi), 64'd0);
        check("midrst_irq", 64'(timer_irq), 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        do_write("post_rst_msip", 16'h0000, 64'd1, 8'h0F, 8'd0, 2'b00, 0, wc);
        check("post_rst_ipi", 64'(ipi), 64'd1);
        do_read("post_rst_cmp", 16'h4000, 8'd0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 2'b00, 0, d);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
